pipe_add: RTL and testbench

- Parametrised, pipelined integer adder/subtractor; the registered successor of the single-cycle ALU adder.
- Splits the WIDTH-bit carry chain into STAGES equal segments, one segment per pipeline stage, to meet timing at wide widths.
- Adds optional signed saturation, a pass-through tag, a valid/ready handshake with full backpressure, and a synchronous flush.
- Used by the multi-cycle execute path and the address-generation unit.

---
 rtl/pipe_add_pkg.sv | 23 ++
 rtl/add_seg.sv | 28 ++
 rtl/pipe_add.sv | 134 +++++++++++++
 tb/tb_pipe_add.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_add_pkg.sv
// Shared types and helpers for the segmented pipelined adder/subtractor.
package pipe_add_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // Width-independent part of a stage register; the final stage reuses it for result flags.
   typedef struct packed {
      logic carry;
      logic zero;
      op_e  op;
      logic sat;
      logic ovf;
      logic satd;
   } stage_ctrl_t;

   function automatic int unsigned seg_width(input int unsigned width, input int unsigned stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational SEG-bit adder slice: one segment of the pipelined carry chain.
module add_seg
   import pipe_add_pkg::*;
#(
   parameter int unsigned SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           a_msb,
   output logic           b_msb,
   output logic           zero
);

   logic [SEG:0] t;

   always_comb begin
      t     = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
      s     = t[SEG-1:0];
      co    = t[SEG];
      a_msb = a[SEG-1];
      b_msb = b[SEG-1];
      zero  = (t[SEG-1:0] == '0);
   end

endmodule

// File: rtl/pipe_add.sv
// Pipelined adder/subtractor: one carry-chain segment per stage, global stall, flush, saturation.
module pipe_add
   import pipe_add_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_in,
   input  logic             valid_in,
   output logic             ready_out,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             neg_b_in,
   input  logic             sat_in,
   input  logic [TAG_W-1:0] tag_in,
   output logic             valid_out,
   input  logic             ready_in,
   output logic [WIDTH-1:0] sum_out,
   output logic             carry_out,
   output logic             overflow_out,
   output logic             zero_out,
   output logic             neg_out,
   output logic             sat_out,
   output logic [TAG_W-1:0] tag_out
);

   localparam int unsigned SEG  = seg_width(WIDTH, STAGES);
   localparam int unsigned LAST = STAGES - 1;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // acc holds result segments below the current stage and untouched A segments above it
   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [WIDTH-1:0] acc;
      logic [WIDTH-1:0] b;
      stage_ctrl_t      ctrl;
   } stage_t;

   stage_t         src    [STAGES];
   stage_t         pipe_d [STAGES];
   stage_t         pipe_q [STAGES];
   logic [SEG-1:0] seg_a  [STAGES];
   logic [SEG-1:0] seg_b  [STAGES];
   logic [SEG-1:0] seg_s  [STAGES];
   logic           seg_ci [STAGES];
   logic           seg_co [STAGES];
   logic           seg_am [STAGES];
   logic           seg_bm [STAGES];
   logic           seg_z  [STAGES];
   logic           advance;

   assign advance   = ~(pipe_q[LAST].valid & ~ready_in);
   assign ready_out = advance;

   always_comb begin
      src[0]            = '0;
      src[0].valid      = valid_in;
      src[0].tag        = tag_in;
      src[0].acc        = a_in;
      src[0].b          = b_in;
      src[0].ctrl.carry = neg_b_in;
      src[0].ctrl.zero  = 1'b1;
      src[0].ctrl.op    = neg_b_in ? OP_SUB : OP_ADD;
      src[0].ctrl.sat   = sat_in;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src[k] = pipe_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         seg_a[k]  = src[k].acc[k*SEG +: SEG];
         seg_b[k]  = (src[k].ctrl.op == OP_SUB) ? ~src[k].b[k*SEG +: SEG] : src[k].b[k*SEG +: SEG];
         seg_ci[k] = src[k].ctrl.carry;
      end
   end

   for (genvar g = 0; g < STAGES; g++) begin : g_seg
      add_seg #(.SEG(SEG)) u_seg (
         .a     (seg_a[g]),
         .b     (seg_b[g]),
         .ci    (seg_ci[g]),
         .s     (seg_s[g]),
         .co    (seg_co[g]),
         .a_msb (seg_am[g]),
         .b_msb (seg_bm[g]),
         .zero  (seg_z[g])
      );
   end

   always_comb begin
      for (int unsigned k = 0; k < STAGES; k++) begin
         pipe_d[k]                    = src[k];
         pipe_d[k].acc[k*SEG +: SEG]  = seg_s[k];
         pipe_d[k].ctrl.carry         = seg_co[k];
         pipe_d[k].ctrl.zero          = src[k].ctrl.zero & seg_z[k];
      end
      // Final stage resolves flags before the output register so outputs are plain flops.
      pipe_d[LAST].ctrl.ovf  = ~(seg_am[LAST] ^ seg_bm[LAST]) & (seg_am[LAST] ^ seg_s[LAST][SEG-1]);
      pipe_d[LAST].ctrl.satd = src[LAST].ctrl.sat & pipe_d[LAST].ctrl.ovf;
      if (pipe_d[LAST].ctrl.satd) begin
         pipe_d[LAST].acc       = seg_am[LAST] ? SAT_MIN : SAT_MAX;
         pipe_d[LAST].ctrl.zero = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pipe_q[k] <= '0;
         end
      end else if (flush_in) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pipe_q[k].valid <= 1'b0;
         end
      end else if (advance) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
      end
   end

   assign valid_out    = pipe_q[LAST].valid;
   assign sum_out      = pipe_q[LAST].acc;
   assign carry_out    = pipe_q[LAST].ctrl.carry;
   assign overflow_out = pipe_q[LAST].ctrl.ovf;
   assign zero_out     = pipe_q[LAST].ctrl.zero;
   assign neg_out      = pipe_q[LAST].acc[WIDTH-1];
   assign sat_out      = pipe_q[LAST].ctrl.satd;
   assign tag_out      = pipe_q[LAST].tag;

endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add: directed table, random traffic vs. arithmetic model, flush, reset, stage sweep.
module tb_pipe_add;

   localparam int unsigned W  = 32;
   localparam int unsigned S  = 4;
   localparam int unsigned TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush_in = 1'b0;
   logic          valid_in = 1'b0;
   logic          ready_in = 1'b1;
   logic          neg_b_in = 1'b0;
   logic          sat_in = 1'b0;
   logic [W-1:0]  a_in = '0;
   logic [W-1:0]  b_in = '0;
   logic [TW-1:0] tag_in = '0;

   logic          ready_out, valid_out, carry_out, overflow_out, zero_out, neg_out, sat_out;
   logic [W-1:0]  sum_out;
   logic [TW-1:0] tag_out;

   logic          x_rdy [3];
   logic          x_valid [3];
   logic [W-1:0]  x_sum [3];
   logic          x_c [3];
   logic          x_ov [3];
   logic          x_z [3];
   logic          x_n [3];
   logic          x_s [3];
   logic [TW-1:0] x_tag [3];

   always #5 clk = ~clk;

   pipe_add #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .valid_in(valid_in), .ready_out(ready_out),
      .a_in(a_in), .b_in(b_in), .neg_b_in(neg_b_in), .sat_in(sat_in), .tag_in(tag_in),
      .valid_out(valid_out), .ready_in(ready_in), .sum_out(sum_out), .carry_out(carry_out),
      .overflow_out(overflow_out), .zero_out(zero_out), .neg_out(neg_out), .sat_out(sat_out),
      .tag_out(tag_out)
   );

   for (genvar g = 0; g < 3; g++) begin : g_sweep
      pipe_add #(.WIDTH(W), .STAGES(g == 0 ? 1 : (g == 1 ? 8 : 32)), .TAG_W(TW)) u_dut (
         .clk(clk), .rst_n(rst_n), .flush_in(flush_in), .valid_in(valid_in), .ready_out(x_rdy[g]),
         .a_in(a_in), .b_in(b_in), .neg_b_in(neg_b_in), .sat_in(sat_in), .tag_in(tag_in),
         .valid_out(x_valid[g]), .ready_in(ready_in), .sum_out(x_sum[g]), .carry_out(x_c[g]),
         .overflow_out(x_ov[g]), .zero_out(x_z[g]), .neg_out(x_n[g]), .sat_out(x_s[g]),
         .tag_out(x_tag[g])
      );
   end

   typedef struct packed {
      logic [31:0] sum;
      logic        c, ov, z, n, s;
      logic [3:0]  tag;
   } res_t;

   typedef struct packed {
      logic [31:0] a, b;
      logic        neg, sat;
      logic [31:0] sum;
      logic        c, ov, z, n, s;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   int   n_out = 0;
   res_t expq [$];
   vec_t vt [10];
   logic done = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference: true signed result in 64-bit arithmetic, clamped to the 32-bit range when asked.
   function automatic res_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                      input logic neg, input logic sat, input logic [3:0] tag);
      res_t r;
      longint sa, sb, v;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'(a) & 64'hFFFF_FFFF;
      ub = longint'(b) & 64'hFFFF_FFFF;
      v  = neg ? sa - sb : sa + sb;
      r.ov  = (v > 64'sd2147483647) || (v < -64'sd2147483648);
      r.c   = neg ? (a >= b) : ((ua + ub) >= 64'h1_0000_0000);
      r.s   = sat && r.ov;
      if (r.s) r.sum = (v > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      else     r.sum = 32'(v);
      r.z   = (r.sum == 32'h0);
      r.n   = r.sum[31];
      r.tag = tag;
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         expq.delete();
      end else begin
         check("ready_out", 64'(ready_out), 64'(!(valid_out && !ready_in)));
         if (valid_out && ready_in) begin
            res_t e;
            n_out++;
            if (expq.size() == 0) begin
               check("spurious_out", 64'(1), 64'(0));
            end else begin
               e = expq.pop_front();
               check("result", 64'({sum_out, carry_out, overflow_out, zero_out, neg_out, sat_out, tag_out}),
                     64'(e));
            end
         end
         if (flush_in) expq.delete();
         if (valid_in && ready_out && !flush_in)
            expq.push_back(ref_model(a_in, b_in, neg_b_in, sat_in, tag_in));
      end
   end

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic neg,
                           input logic sat, input logic [3:0] tag);
      a_in = a; b_in = b; neg_b_in = neg; sat_in = sat; tag_in = tag; valid_in = 1'b1;
   endtask

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic neg,
                       input logic sat, input logic [3:0] tag);
      int w;
      w = 0;
      drive_op(a, b, neg, sat, tag);
      @(negedge clk);
      while (!ready_out && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) check("accept_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic wait_latency(output int lat);
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         if (valid_out) begin
            lat = n;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((expq.size() != 0 || valid_out) && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      check("drain", 64'(expq.size()), 64'(0));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h0000_0001;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      #200000;
      check("watchdog", 64'(0), 64'(1));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int lat;
      int base;
      int seen;
      int xl [3];
      res_t xr [3];
      res_t ev;

      vt = '{
         '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
         '{32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
         '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
         '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1},
         '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
         '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
         '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
         '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
         '{32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}
      };

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 64'({valid_out, sum_out, carry_out, overflow_out, zero_out, neg_out, sat_out, tag_out}),
            64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'(ready_out), 64'(1));
      @(posedge clk);
      #1;

      // Directed table: constant expectations and STAGES-1 cycles after the accept edge
      for (int i = 0; i < 10; i++) begin
         send(vt[i].a, vt[i].b, vt[i].neg, vt[i].sat, 4'(i));
         wait_latency(lat);
         check($sformatf("latency_vec%0d", i), 64'(lat), 64'(S - 1));
         ev = '{vt[i].sum, vt[i].c, vt[i].ov, vt[i].z, vt[i].n, vt[i].s, 4'(i)};
         check($sformatf("vec%0d", i),
               64'({sum_out, carry_out, overflow_out, zero_out, neg_out, sat_out, tag_out}), 64'(ev));
         @(posedge clk);
         #1;
      end
      drain();

      // 16 back-to-back ops with a 3-cycle consumer stall
      base = n_out;
      fork
         begin
            for (int i = 0; i < 16; i++)
               send($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
         end
         begin
            repeat (6) @(posedge clk);
            #1;
            ready_in = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            ready_in = 1'b1;
         end
      join
      drain();
      check("burst_count", 64'(n_out - base), 64'(16));

      // Random traffic with random backpressure
      base = n_out;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(i));
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               ready_in = ($urandom_range(0, 3) != 0);
            end
            ready_in = 1'b1;
         end
      join
      drain();
      check("random_count", 64'(n_out - base), 64'(60));

      // Flush with three ops in flight; an op offered during flush is dropped
      send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 4'd1);
      send(32'h0000_0010, 32'h0000_0003, 1'b1, 1'b0, 4'd2);
      send(32'h7FFF_FFFF, 32'h0000_0005, 1'b0, 1'b1, 4'd3);
      drive_op(32'h0000_0007, 32'h0000_0008, 1'b0, 1'b0, 4'd9);
      flush_in = 1'b1;
      @(negedge clk);
      check("ready_during_flush", 64'(ready_out), 64'(1));
      @(posedge clk);
      #1;
      flush_in = 1'b0;
      valid_in = 1'b0;
      seen = 0;
      repeat (8) begin
         if (valid_out) seen++;
         @(posedge clk);
         #1;
      end
      check("flush_no_out", 64'(seen), 64'(0));
      send(32'h0000_0100, 32'h0000_0023, 1'b0, 1'b0, 4'd10);
      wait_latency(lat);
      check("latency_after_flush", 64'(lat), 64'(S - 1));
      check("sum_after_flush", 64'(sum_out), 64'(32'h0000_0123));
      drain();

      // Asynchronous reset in the middle of a stream
      for (int i = 0; i < 5; i++)
         send($urandom(), $urandom(), 1'b0, 1'b0, 4'(i));
      check("pre_reset_valid", 64'(valid_out), 64'(1));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outs",
            64'({valid_out, sum_out, carry_out, overflow_out, zero_out, neg_out, sat_out, tag_out}), 64'(0));
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         if (valid_out) seen++;
         @(posedge clk);
         #1;
      end
      check("no_out_after_reset", 64'(seen), 64'(0));

      // Carry-propagation sweep across STAGES = 1, 8, 32
      for (int g = 0; g < 3; g++) begin
         check($sformatf("sweep_ready%0d", g), 64'(x_rdy[g]), 64'(1));
         xl[g] = -1;
         xr[g] = '0;
      end
      send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 4'd5);
      for (int n = 0; n < 40; n++) begin
         for (int g = 0; g < 3; g++) begin
            if (x_valid[g] && xl[g] < 0) begin
               xl[g] = n;
               xr[g] = '{x_sum[g], x_c[g], x_ov[g], x_z[g], x_n[g], x_s[g], x_tag[g]};
            end
         end
         @(posedge clk);
         #1;
      end
      check("sweep_lat_s1", 64'(xl[0]), 64'(0));
      check("sweep_lat_s8", 64'(xl[1]), 64'(7));
      check("sweep_lat_s32", 64'(xl[2]), 64'(31));
      ev = '{32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5};
      for (int g = 0; g < 3; g++)
         check($sformatf("sweep_res%0d", g), 64'(xr[g]), 64'(ev));
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
